// File: rtl/word_pkg.sv
// Shared word and destination-select types for the word mux and demux blocks.
package word_pkg;

    localparam int WORD_W = 16;
    localparam int SEL_W  = 2;
    localparam int NOUT   = 2 ** SEL_W;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [SEL_W-1:0]  sel_t;
    typedef logic [NOUT-1:0]   chan_mask_t;

    // One-hot channel mask for a destination index.
    function automatic chan_mask_t sel_decode(input sel_t sel);
        chan_mask_t mask;
        mask      = '0;
        mask[sel] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/word_demux_if.sv
// Producer + per-channel consumer handshake bundle for word_demux.
// i_bcast exists only when WORD_DEMUX_BCAST_EN is defined.
interface word_demux_if;
    import word_pkg::*;

    logic                    i_valid;
    logic                    o_ready;
    sel_t                    i_sel;
    word_t                   i_data;
`ifdef WORD_DEMUX_BCAST_EN
    logic                    i_bcast;
`endif
    chan_mask_t              o_valid;
    chan_mask_t              i_ready;
    logic [NOUT*WORD_W-1:0]  o_data;

`ifdef WORD_DEMUX_BCAST_EN
    modport slave (
        input  i_valid, i_sel, i_data, i_bcast, i_ready,
        output o_ready, o_valid, o_data
    );
    modport master (
        output i_valid, i_sel, i_data, i_bcast, i_ready,
        input  o_ready, o_valid, o_data
    );
`else
    modport slave (
        input  i_valid, i_sel, i_data, i_ready,
        output o_ready, o_valid, o_data
    );
    modport master (
        output i_valid, i_sel, i_data, i_ready,
        input  o_ready, o_valid, o_data
    );
`endif

endinterface

// File: rtl/demux_slot.sv
// One-entry holding register for a single demux output channel.
// Accepts a new word while the old one drains, so a ready consumer sees no bubble.
module demux_slot
    import word_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  word_t d,
    input  logic  i_ready,
    output logic  o_valid,
    output word_t o_data,
    output logic  can_take
);

    logic  full_reg;
    word_t data_reg;

    assign can_take = !full_reg || i_ready;
    assign o_valid  = full_reg;
    assign o_data   = data_reg;

    // Data is held after a drain; only a load or reset changes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_reg <= 1'b0;
            data_reg <= '0;
        end else if (load) begin
            full_reg <= 1'b1;
            data_reg <= d;
        end else if (i_ready) begin
            full_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/word_demux.sv
// Registered 1-to-NOUT word demultiplexer with per-channel valid/ready.
// Optional broadcast to every channel under WORD_DEMUX_BCAST_EN.
module word_demux
    import word_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    word_demux_if.slave  bus
);

    chan_mask_t             can_take;
    chan_mask_t             slot_valid;
    chan_mask_t             dest_mask;
    chan_mask_t             load_mask;
    word_t                  slot_data [NOUT];
    logic [NOUT*WORD_W-1:0] data_flat;
    logic                   accept;

`ifdef WORD_DEMUX_BCAST_EN
    // A broadcast waits until every channel can take the word at once.
    assign dest_mask   = bus.i_bcast ? '1 : sel_decode(bus.i_sel);
    assign bus.o_ready = bus.i_bcast ? (&can_take) : can_take[bus.i_sel];
`else
    assign dest_mask   = sel_decode(bus.i_sel);
    assign bus.o_ready = can_take[bus.i_sel];
`endif

    assign accept    = bus.i_valid && bus.o_ready;
    assign load_mask = {NOUT{accept}} & dest_mask;

    generate
        for (genvar gi = 0; gi < NOUT; gi++) begin : g_slot
            demux_slot u_slot (
                .clk      (i_clk),
                .rst_n    (i_rst_n),
                .load     (load_mask[gi]),
                .d        (bus.i_data),
                .i_ready  (bus.i_ready[gi]),
                .o_valid  (slot_valid[gi]),
                .o_data   (slot_data[gi]),
                .can_take (can_take[gi])
            );
        end
    endgenerate

    always_comb begin
        data_flat = '0;
        for (int k = 0; k < NOUT; k++) begin
            data_flat[k*WORD_W +: WORD_W] = slot_data[k];
        end
    end

    assign bus.o_valid = slot_valid;
    assign bus.o_data  = data_flat;

endmodule

// File: tb/tb_word_demux.sv
// Self-checking bench for word_demux: vector table, reset/broadcast sequences,
// and a random stream against a per-channel scoreboard.
module tb_word_demux;
    import word_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    word_demux_if dif ();

    word_demux dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (dif.slave)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input sel_t s, input word_t d, input logic [3:0] r);
        dif.i_valid = v;
        dif.i_sel   = s;
        dif.i_data  = d;
        dif.i_ready = r;
    endtask

    property p_hold;
        @(posedge clk) disable iff (!rst_n)
            (dif.i_valid && !dif.o_ready) |=>
            (!dif.i_valid || ($stable(dif.i_sel) && $stable(dif.i_data)));
    endproperty
    a_hold: assert property (p_hold) else $error("producer contract broken");

`ifdef WORD_DEMUX_BCAST_EN
    property p_hold_bcast;
        @(posedge clk) disable iff (!rst_n)
            (dif.i_valid && !dif.o_ready) |=> (!dif.i_valid || $stable(dif.i_bcast));
    endproperty
    a_hold_bcast: assert property (p_hold_bcast) else $error("producer contract broken");
`endif

    // Scoreboard, sampled mid-cycle: the values seen here are those the next edge acts on.
    word_t sb_q [NOUT][$];
    logic  sb_on    = 1'b0;
    int    n_pushed = 0;
    int    n_popped = 0;

    always @(negedge clk) begin
        if (sb_on) begin
            if (dif.i_valid && dif.o_ready) begin
                sb_q[dif.i_sel].push_back(dif.i_data);
                n_pushed++;
            end
            for (int k = 0; k < NOUT; k++) begin
                if (dif.o_valid[k] && dif.i_ready[k]) begin
                    if (sb_q[k].size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL stream_dup ch%0d: got word %h expected none", k,
                                 dif.o_data[k*WORD_W +: WORD_W]);
                    end else begin
                        chk($sformatf("stream_data_ch%0d", k),
                            64'(dif.o_data[k*WORD_W +: WORD_W]), 64'(sb_q[k].pop_front()));
                        n_popped++;
                    end
                end
            end
        end
    end

    typedef struct {
        logic        valid;
        sel_t        sel;
        word_t       data;
        logic [3:0]  rdy;
        logic        exp_ordy;
        logic [3:0]  exp_ovalid;
        logic [63:0] exp_odata;
    } vec_t;

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{1'b1, 2'd2, 16'hA5C3, 4'b1111, 1'b1, 4'b0100, 64'h0000_A5C3_0000_0000};
        vecs[1]  = '{1'b0, 2'd0, 16'h0000, 4'b1111, 1'b1, 4'b0000, 64'h0000_A5C3_0000_0000};
        vecs[2]  = '{1'b1, 2'd1, 16'h0001, 4'b1101, 1'b1, 4'b0010, 64'h0000_A5C3_0001_0000};
        vecs[3]  = '{1'b1, 2'd1, 16'h0002, 4'b1101, 1'b0, 4'b0010, 64'h0000_A5C3_0001_0000};
        vecs[4]  = '{1'b0, 2'd1, 16'h0002, 4'b1101, 1'b0, 4'b0010, 64'h0000_A5C3_0001_0000};
        vecs[5]  = '{1'b1, 2'd0, 16'h0BEE, 4'b1101, 1'b1, 4'b0011, 64'h0000_A5C3_0001_0BEE};
        vecs[6]  = '{1'b1, 2'd1, 16'h0002, 4'b1111, 1'b1, 4'b0010, 64'h0000_A5C3_0002_0BEE};
        vecs[7]  = '{1'b0, 2'd0, 16'h0000, 4'b1111, 1'b1, 4'b0000, 64'h0000_A5C3_0002_0BEE};
        vecs[8]  = '{1'b1, 2'd3, 16'h1111, 4'b0111, 1'b1, 4'b1000, 64'h1111_A5C3_0002_0BEE};
        vecs[9]  = '{1'b1, 2'd3, 16'h2222, 4'b1111, 1'b1, 4'b1000, 64'h2222_A5C3_0002_0BEE};
        vecs[10] = '{1'b0, 2'd3, 16'h0000, 4'b1111, 1'b1, 4'b0000, 64'h2222_A5C3_0002_0BEE};
        vecs[11] = '{1'b1, 2'd3, 16'h3333, 4'b0111, 1'b1, 4'b1000, 64'h3333_A5C3_0002_0BEE};
        vecs[12] = '{1'b0, 2'd3, 16'h0000, 4'b0111, 1'b0, 4'b1000, 64'h3333_A5C3_0002_0BEE};
        vecs[13] = '{1'b0, 2'd3, 16'h0000, 4'b1111, 1'b1, 4'b0000, 64'h3333_A5C3_0002_0BEE};

        drive(1'b0, 2'd0, 16'h0000, 4'b0000);
`ifdef WORD_DEMUX_BCAST_EN
        dif.i_bcast = 1'b0;
`endif

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ovalid", 64'(dif.o_valid), 64'h0);
        chk("reset_odata", dif.o_data, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_oready", 64'(dif.o_ready), 64'h1);

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].valid, vecs[i].sel, vecs[i].data, vecs[i].rdy);
            @(negedge clk);
            chk($sformatf("vec%0d_oready", i), 64'(dif.o_ready), 64'(vecs[i].exp_ordy));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_ovalid", i), 64'(dif.o_valid), 64'(vecs[i].exp_ovalid));
            chk($sformatf("vec%0d_odata", i), dif.o_data, vecs[i].exp_odata);
            $display("vec %0d: valid=%0b sel=%0d data=%h rdy=%b -> o_valid=%b", i,
                     vecs[i].valid, vecs[i].sel, vecs[i].data, vecs[i].rdy, dif.o_valid);
        end

        // Reset mid-operation with channels 1 and 3 full
        drive(1'b1, 2'd1, 16'h1234, 4'b0101);
        @(posedge clk);
        #1;
        drive(1'b1, 2'd3, 16'h5678, 4'b0101);
        @(posedge clk);
        #1;
        drive(1'b0, 2'd3, 16'h0000, 4'b0101);
        chk("midrst_pre_ovalid", 64'(dif.o_valid), 64'b1010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ovalid", 64'(dif.o_valid), 64'h0);
        chk("midrst_odata", dif.o_data, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_oready", 64'(dif.o_ready), 64'h1);
        @(posedge clk);
        #1;
        chk("midrst_post_ovalid", 64'(dif.o_valid), 64'h0);
        $display("mid-stream reset: o_valid=%b o_ready=%0b", dif.o_valid, dif.o_ready);

        // Random stream against the scoreboard
        sb_on = 1'b1;
        for (int w = 0; w < 256; w++) begin
            logic accepted;
            int   waited;
            sel_t s;
            word_t d;
            s        = sel_t'($urandom_range(NOUT - 1, 0));
            d        = word_t'($urandom);
            accepted = 1'b0;
            waited   = 0;
            while (!accepted && waited < 100) begin
                drive(1'b1, s, d, 4'($urandom));
                @(negedge clk);
                accepted = dif.o_ready;
                @(posedge clk);
                #1;
                waited++;
            end
            if (!accepted) begin
                n_cmp++;
                n_fail++;
                $display("FAIL stream_timeout word %0d: got no accept expected accept in 100 cycles", w);
            end else begin
                $display("stream word %0d -> ch%0d data %h (%0d cycles)", w, s, d, waited);
            end
        end
        drive(1'b0, 2'd0, 16'h0000, 4'b1111);
        repeat (3) @(posedge clk);
        #1;
        sb_on = 1'b0;
        for (int k = 0; k < NOUT; k++) begin
            chk($sformatf("stream_left_ch%0d", k), 64'(sb_q[k].size()), 64'h0);
        end
        chk("stream_pushed", 64'(n_pushed), 64'd256);
        chk("stream_popped", 64'(n_popped), 64'd256);

`ifdef WORD_DEMUX_BCAST_EN
        // Broadcast blocked by a stalled, full channel 0
        drive(1'b1, 2'd0, 16'h0AAA, 4'b1110);
        @(posedge clk);
        #1;
        dif.i_bcast = 1'b1;
        drive(1'b1, 2'd0, 16'hFFFF, 4'b1110);
        @(negedge clk);
        chk("bcast_stall_oready", 64'(dif.o_ready), 64'h0);
        @(posedge clk);
        #1;
        chk("bcast_stall_ovalid", 64'(dif.o_valid), 64'b0001);
        dif.i_ready = 4'b1111;
        @(negedge clk);
        chk("bcast_go_oready", 64'(dif.o_ready), 64'h1);
        @(posedge clk);
        #1;
        chk("bcast_ovalid", 64'(dif.o_valid), 64'b1111);
        chk("bcast_odata", dif.o_data, 64'hFFFF_FFFF_FFFF_FFFF);
        $display("broadcast: o_valid=%b o_data=%h", dif.o_valid, dif.o_data);
        dif.i_bcast = 1'b0;
        drive(1'b0, 2'd0, 16'h0000, 4'b1111);
        @(posedge clk);
        #1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
